mer_sweep_controller: RTL

- Sequences the MER measurement DUT through a programmable list of isi_power settings.
- For each setting it waits for the channel pipeline to settle, then accumulates error power and errorless signal power over 2^LOG2_N symbols and reports both sums through a valid/ready handshake.
- Sits between the host/config interface and the MER stimulus DUT, in the clk domain, advancing on sym_clk_en.

---
 rtl/mer_sweep_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mer_sweep_controller.sv
// mer_sweep_controller: steps the MER DUT through a table of isi_power values.
// For each step it lets the channel settle, then sums error and errorless
// signal power over 2^LOG2_N symbols.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   sym_clk_en                 symbol-rate enable, one clk wide
//   start                      begin a sweep, sampled in IDLE only
//   cfg_we, cfg_addr, cfg_data isi_power table write port, honoured in IDLE only
//   cfg_num_steps              steps per sweep, clamped to MAX_STEPS, captured at start
//   dut_error, dut_errorless   signed samples from the DUT
//   isi_power                  registered drive to the DUT
//   busy, done                 sweep in progress / one-clk end-of-sweep pulse
//   res_valid, res_ready       result handshake
//   res_step, res_err_acc, res_sig_acc  result payload
//   res_err_peak               peak |dut_error| of the step, present only when
//                              MER_PEAK_TRACK_EN is defined
module mer_sweep_controller #(
   parameter int DATA_WIDTH  = 18,
   parameter int MAX_STEPS   = 16,
   parameter int LOG2_N      = 10,
   parameter int SETTLE_SYMS = 8,
   localparam int AW   = $clog2(MAX_STEPS),
   localparam int ACCW = 2*DATA_WIDTH+LOG2_N
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sym_clk_en,
   input  logic                  start,
   input  logic                  cfg_we,
   input  logic [AW-1:0]         cfg_addr,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic [AW:0]           cfg_num_steps,
   input  logic [DATA_WIDTH-1:0] dut_error,
   input  logic [DATA_WIDTH-1:0] dut_errorless,
   output logic [DATA_WIDTH-1:0] isi_power,
   output logic                  busy,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [AW-1:0]         res_step,
   output logic [ACCW-1:0]       res_err_acc,
   output logic [ACCW-1:0]       res_sig_acc,
`ifdef MER_PEAK_TRACK_EN
   output logic [DATA_WIDTH-2:0] res_err_peak,
`endif
   output logic                  done
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_ACCUM  = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;
   localparam logic [2:0] S_FIN    = 3'd5;
   localparam int SW = $clog2(SETTLE_SYMS);
   logic [2:0]                     state_q, state_d;
   logic                           busy_q, busy_d, res_valid_q, res_valid_d;
   logic [AW-1:0]                  step_q, step_d, res_step_q, res_step_d;
   logic [AW:0]                    num_q, num_d, num_clamp;
   logic [SW-1:0]                  settle_q, settle_d;
   logic [LOG2_N-1:0]              cnt_q, cnt_d;
   logic [ACCW-1:0]                err_acc_q, err_acc_d, sig_acc_q, sig_acc_d;
   logic [ACCW-1:0]                res_err_q, res_err_d, res_sig_q, res_sig_d;
   logic [ACCW-1:0]                err_sum, sig_sum;
   logic [DATA_WIDTH-1:0]          isi_q, isi_d;
   logic [DATA_WIDTH-1:0]          table_q [MAX_STEPS];
   logic signed [2*DATA_WIDTH-1:0] err_sq, sig_sq;
   logic                           last_step;
   assign num_clamp = (cfg_num_steps > (AW+1)'(MAX_STEPS)) ? (AW+1)'(MAX_STEPS) : cfg_num_steps;
   assign last_step = {1'b0, step_q} == num_q - (AW+1)'(1);
   // squares of signed samples are never negative, so plain zero-extension is exact
   assign err_sq    = $signed(dut_error) * $signed(dut_error);
   assign sig_sq    = $signed(dut_errorless) * $signed(dut_errorless);
   assign err_sum   = err_acc_q + {{LOG2_N{1'b0}}, err_sq};
   assign sig_sum   = sig_acc_q + {{LOG2_N{1'b0}}, sig_sq};
`ifdef MER_PEAK_TRACK_EN
   logic [DATA_WIDTH-2:0] peak_q, peak_d, res_peak_q, res_peak_d, err_abs, peak_max;
   logic [DATA_WIDTH-1:0] err_neg;
   assign err_neg  = -dut_error;
   // only the most negative input still has its sign bit set after negation; it saturates
   assign err_abs  = !dut_error[DATA_WIDTH-1] ? dut_error[DATA_WIDTH-2:0] :
                     err_neg[DATA_WIDTH-1] ? '1 : err_neg[DATA_WIDTH-2:0];
   assign peak_max = (err_abs > peak_q) ? err_abs : peak_q;
   assign res_err_peak = res_peak_q;
`endif
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      step_d      = step_q;
      num_d       = num_q;
      settle_d    = settle_q;
      cnt_d       = cnt_q;
      err_acc_d   = err_acc_q;
      sig_acc_d   = sig_acc_q;
      isi_d       = isi_q;
      res_valid_d = res_valid_q;
      res_step_d  = res_step_q;
      res_err_d   = res_err_q;
      res_sig_d   = res_sig_q;
`ifdef MER_PEAK_TRACK_EN
      peak_d      = peak_q;
      res_peak_d  = res_peak_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            busy_d  = 1'b1;
            step_d  = '0;
            num_d   = num_clamp;
            state_d = (num_clamp == '0) ? S_FIN : S_LOAD;
         end
         S_LOAD: begin
            isi_d     = table_q[step_q];
            settle_d  = '0;
            cnt_d     = '0;
            err_acc_d = '0;
            sig_acc_d = '0;
`ifdef MER_PEAK_TRACK_EN
            peak_d    = '0;
`endif
            state_d   = S_SETTLE;
         end
         S_SETTLE: if (sym_clk_en) begin
            settle_d = settle_q + SW'(1);
            state_d  = (settle_q == SW'(SETTLE_SYMS-1)) ? S_ACCUM : S_SETTLE;
         end
         S_ACCUM: if (sym_clk_en) begin
            err_acc_d = err_sum;
            sig_acc_d = sig_sum;
            cnt_d     = cnt_q + LOG2_N'(1);
`ifdef MER_PEAK_TRACK_EN
            peak_d    = peak_max;
`endif
            if (&cnt_q) begin
               res_valid_d = 1'b1;
               res_step_d  = step_q;
               res_err_d   = err_sum;
               res_sig_d   = sig_sum;
`ifdef MER_PEAK_TRACK_EN
               res_peak_d  = peak_max;
`endif
               state_d     = S_REPORT;
            end
         end
         // symbols arriving here are dropped; the next step re-settles anyway
         S_REPORT: if (res_ready) begin
            res_valid_d = 1'b0;
            step_d      = last_step ? step_q : step_q + AW'(1);
            state_d     = last_step ? S_FIN : S_LOAD;
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         step_q      <= '0;
         num_q       <= '0;
         settle_q    <= '0;
         cnt_q       <= '0;
         err_acc_q   <= '0;
         sig_acc_q   <= '0;
         isi_q       <= '0;
         res_valid_q <= 1'b0;
         res_step_q  <= '0;
         res_err_q   <= '0;
         res_sig_q   <= '0;
`ifdef MER_PEAK_TRACK_EN
         peak_q      <= '0;
         res_peak_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         step_q      <= step_d;
         num_q       <= num_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         err_acc_q   <= err_acc_d;
         sig_acc_q   <= sig_acc_d;
         isi_q       <= isi_d;
         res_valid_q <= res_valid_d;
         res_step_q  <= res_step_d;
         res_err_q   <= res_err_d;
         res_sig_q   <= res_sig_d;
`ifdef MER_PEAK_TRACK_EN
         peak_q      <= peak_d;
         res_peak_q  <= res_peak_d;
`endif
      end
   end
   // table contents survive reset so a sweep can be rerun without reprogramming
   always_ff @(posedge clk) begin
      if (cfg_we && state_q == S_IDLE) table_q[cfg_addr] <= cfg_data;
   end
   assign isi_power   = isi_q;
   assign busy        = busy_q;
   assign res_valid   = res_valid_q;
   assign res_step    = res_step_q;
   assign res_err_acc = res_err_q;
   assign res_sig_acc = res_sig_q;
   assign done        = state_q == S_FIN;
endmodule
